// File: rtl/pkt_avg_mode.sv
// Packet-wise vector averager: accumulates 2^K packets of N samples bin-by-bin and
// emits either the truncated mean or the per-bin peak-hold as one packet per frame.
module pkt_avg_mode #(
  parameter int WIDTH             = 32,
  parameter int MAX_PKT_SIZE_LOG2 = 14,
  parameter int MAX_AVG_LOG2      = 10,
  parameter int DEFAULT_PKT_SIZE  = 1024,
  parameter int DEFAULT_AVG_LOG2  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             i_tdata,
  input  logic                         i_tlast,
  input  logic                         i_tvalid,
  output logic                         i_tready,
  output logic [WIDTH-1:0]             o_tdata,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  input  logic                         o_tready,
  input  logic [MAX_PKT_SIZE_LOG2+4:0] i_config_tdata,
  input  logic                         i_config_tvalid,
  output logic                         i_config_tready,
  output logic                         o_len_err
);
  localparam int M     = MAX_PKT_SIZE_LOG2;
  localparam int A     = WIDTH + MAX_AVG_LOG2;
  localparam int CW    = MAX_AVG_LOG2 + 1;
  localparam int OW    = M + 1;
  localparam int DEPTH = 2 ** M;
  localparam logic [M-1:0] DEF_NM1 = M'(DEFAULT_PKT_SIZE - 1);
  localparam logic [3:0]   DEF_K   = 4'(DEFAULT_AVG_LOG2);

  typedef enum logic [1:0] {ST_FIRST, ST_ACCUM, ST_LAST, ST_RESYNC} state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    idx_q, idx_d, act_nm1_q, act_nm1_d, pend_nm1_q, pend_nm1_d, cur_nm1;
  logic [CW-1:0]   pkt_q, pkt_d, accum_end;
  logic [3:0]      act_k_q, act_k_d, pend_k_q, pend_k_d, cur_k, cfg_k;
  logic            act_mode_q, act_mode_d, pend_mode_q, pend_mode_d, cur_mode;
  logic [OW-1:0]   occ_q, occ_d, free_s, cnt_q, cnt_d;
  logic            len_err_q, len_err_d;
  logic            at_boundary, at_end, last_pkt, accept, cfg_ok, ram_we, fifo_rd;
  logic            s1_valid_q, s1_valid_d, s1_push_q, s1_push_d, s1_term_q, s1_term_d;
  logic            s1_first_q, s1_first_d, s1_tlast_q, s1_tlast_d, s1_mode_q, s1_mode_d;
  logic [M-1:0]    s1_idx_q, s1_idx_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d, out_val;
  logic [3:0]      s1_k_q, s1_k_d;
  logic [A-1:0]    ram_rd_q, sample_ext, acc_op, result;
  logic            push_valid_q, push_valid_d;
  logic [WIDTH:0]  push_data_q, push_data_d;
  logic [M-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d;
  logic [WIDTH-1:0] o_tdata_q, o_tdata_d;

  logic [A-1:0]    acc_ram  [DEPTH];
  logic [WIDTH:0]  fifo_mem [DEPTH];

  // The pending config becomes the active one on the first beat of a frame.
  always_comb begin
    at_boundary = (state_q == ST_FIRST) && (idx_q == M'(0));
    if (at_boundary) begin
      cur_nm1  = pend_nm1_q;
      cur_k    = pend_k_q;
      cur_mode = pend_mode_q;
    end else begin
      cur_nm1  = act_nm1_q;
      cur_k    = act_k_q;
      cur_mode = act_mode_q;
    end
    at_end    = (idx_q == cur_nm1);
    last_pkt  = (state_q == ST_LAST) || ((state_q == ST_FIRST) && (cur_k == 4'd0));
    accum_end = (CW'(1) << cur_k) - CW'(2);
    free_s    = OW'(DEPTH) - occ_q;
    // occ_q counts FIFO entries plus results still in the pipeline, so a whole
    // result packet is reserved before its first beat is accepted.
    i_tready  = !(last_pkt && (idx_q == M'(0)) && ({1'b0, cur_nm1} >= free_s));
    accept    = i_tvalid && i_tready;
    cfg_k     = i_config_tdata[M+3:M];
    cfg_ok    = i_config_tvalid && (i_config_tdata[M-1:0] >= M'(3)) &&
                (cfg_k <= 4'(MAX_AVG_LOG2));
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkt_d      = pkt_q;
    act_nm1_d  = act_nm1_q;
    act_k_d    = act_k_q;
    act_mode_d = act_mode_q;
    len_err_d  = 1'b0;
    s1_valid_d = 1'b0;
    s1_push_d  = 1'b0;
    s1_term_d  = 1'b0;
    s1_first_d = 1'b0;
    s1_tlast_d = 1'b0;
    s1_idx_d   = idx_q;
    s1_data_d  = i_tdata;
    s1_mode_d  = cur_mode;
    s1_k_d     = cur_k;
    if (cfg_ok) begin
      pend_nm1_d  = i_config_tdata[M-1:0];
      pend_k_d    = cfg_k;
      pend_mode_d = i_config_tdata[M+4];
    end else begin
      pend_nm1_d  = pend_nm1_q;
      pend_k_d    = pend_k_q;
      pend_mode_d = pend_mode_q;
    end
    if (accept) begin
      if (at_boundary) begin
        act_nm1_d  = pend_nm1_q;
        act_k_d    = pend_k_q;
        act_mode_d = pend_mode_q;
      end else begin
        act_nm1_d  = act_nm1_q;
      end
      if (state_q == ST_RESYNC) begin
        state_d = i_tlast ? ST_FIRST : ST_RESYNC;
      end else if (i_tlast != at_end) begin
        // Abandon the frame; a result packet in flight is closed by a zero tlast beat.
        len_err_d  = 1'b1;
        idx_d      = M'(0);
        pkt_d      = CW'(0);
        state_d    = i_tlast ? ST_FIRST : ST_RESYNC;
        s1_valid_d = last_pkt;
        s1_push_d  = last_pkt;
        s1_term_d  = 1'b1;
      end else begin
        s1_valid_d = 1'b1;
        s1_push_d  = last_pkt;
        s1_first_d = (state_q == ST_FIRST);
        s1_tlast_d = at_end;
        if (at_end) begin
          idx_d = M'(0);
          case (state_q)
            ST_FIRST: begin
              if (cur_k == 4'd0) begin
                state_d = ST_FIRST;
              end else if (cur_k == 4'd1) begin
                state_d = ST_LAST;
              end else begin
                state_d = ST_ACCUM;
                pkt_d   = CW'(1);
              end
            end
            ST_ACCUM: begin
              pkt_d   = pkt_q + CW'(1);
              state_d = (pkt_q == accum_end) ? ST_LAST : ST_ACCUM;
            end
            ST_LAST: begin
              state_d = ST_FIRST;
              pkt_d   = CW'(0);
            end
            default: begin
              state_d = ST_FIRST;
              pkt_d   = CW'(0);
            end
          endcase
        end else begin
          idx_d = idx_q + M'(1);
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    sample_ext = A'(s1_data_q);
    if (s1_mode_q) begin
      acc_op = (ram_rd_q > sample_ext) ? ram_rd_q : sample_ext;
    end else begin
      acc_op = ram_rd_q + sample_ext;
    end
    result = s1_first_q ? sample_ext : acc_op;
    if (s1_mode_q) begin
      out_val = result[WIDTH-1:0];
    end else begin
      out_val = WIDTH'(result >> s1_k_q);
    end
    ram_we       = s1_valid_q && !s1_push_q;
    push_valid_d = s1_valid_q && s1_push_q;
    push_data_d  = s1_term_q ? {1'b1, {WIDTH{1'b0}}} : {s1_tlast_q, out_val};
  end

  always_comb begin
    fifo_rd  = (cnt_q != OW'(0)) && (!o_tvalid_q || o_tready);
    wr_ptr_d = push_valid_q ? (wr_ptr_q + M'(1)) : wr_ptr_q;
    rd_ptr_d = fifo_rd ? (rd_ptr_q + M'(1)) : rd_ptr_q;
    cnt_d    = cnt_q + OW'(push_valid_q) - OW'(fifo_rd);
    occ_d    = occ_q + OW'(accept && last_pkt) - OW'(o_tvalid_q && o_tready);
    if (fifo_rd) begin
      o_tvalid_d = 1'b1;
      {o_tlast_d, o_tdata_d} = fifo_mem[rd_ptr_q];
    end else if (o_tready) begin
      o_tvalid_d = 1'b0;
      o_tlast_d  = o_tlast_q;
      o_tdata_d  = o_tdata_q;
    end else begin
      o_tvalid_d = o_tvalid_q;
      o_tlast_d  = o_tlast_q;
      o_tdata_d  = o_tdata_q;
    end
  end

  // Accumulator RAM: read on acceptance, written back one cycle later.
  always_ff @(posedge clk) begin
    if (accept) ram_rd_q <= acc_ram[idx_q];
    if (ram_we) acc_ram[s1_idx_q] <= result;
  end

  always_ff @(posedge clk) begin
    if (push_valid_q) fifo_mem[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FIRST;
      idx_q        <= M'(0);
      pkt_q        <= CW'(0);
      act_nm1_q    <= DEF_NM1;
      act_k_q      <= DEF_K;
      act_mode_q   <= 1'b0;
      pend_nm1_q   <= DEF_NM1;
      pend_k_q     <= DEF_K;
      pend_mode_q  <= 1'b0;
      occ_q        <= OW'(0);
      cnt_q        <= OW'(0);
      wr_ptr_q     <= M'(0);
      rd_ptr_q     <= M'(0);
      len_err_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_push_q    <= 1'b0;
      s1_term_q    <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_tlast_q   <= 1'b0;
      s1_idx_q     <= M'(0);
      s1_data_q    <= {WIDTH{1'b0}};
      s1_mode_q    <= 1'b0;
      s1_k_q       <= 4'd0;
      push_valid_q <= 1'b0;
      push_data_q  <= {(WIDTH+1){1'b0}};
      o_tvalid_q   <= 1'b0;
      o_tlast_q    <= 1'b0;
      o_tdata_q    <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pkt_q        <= pkt_d;
      act_nm1_q    <= act_nm1_d;
      act_k_q      <= act_k_d;
      act_mode_q   <= act_mode_d;
      pend_nm1_q   <= pend_nm1_d;
      pend_k_q     <= pend_k_d;
      pend_mode_q  <= pend_mode_d;
      occ_q        <= occ_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_err_q    <= len_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_push_q    <= s1_push_d;
      s1_term_q    <= s1_term_d;
      s1_first_q   <= s1_first_d;
      s1_tlast_q   <= s1_tlast_d;
      s1_idx_q     <= s1_idx_d;
      s1_data_q    <= s1_data_d;
      s1_mode_q    <= s1_mode_d;
      s1_k_q       <= s1_k_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      o_tvalid_q   <= o_tvalid_d;
      o_tlast_q    <= o_tlast_d;
      o_tdata_q    <= o_tdata_d;
    end
  end

  assign o_tvalid        = o_tvalid_q;
  assign o_tlast         = o_tlast_q;
  assign o_tdata         = o_tdata_q;
  assign o_len_err       = len_err_q;
  assign i_config_tready = 1'b1;
endmodule

// File: tb/tb_pkt_avg_mode.sv
// Directed bench for pkt_avg_mode: expected result beats are queued when stimulus is
// driven and compared, in order, as the DUT hands them out.
module tb_pkt_avg_mode;
  logic        clk;
  logic        reset;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [8:0]  i_config_tdata;
  logic        i_config_tvalid;
  logic        i_config_tready;
  logic        o_len_err;

  int passed = 0;
  int total = 0;
  int len_err_cnt = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_beat;

  pkt_avg_mode #(
    .WIDTH(32), .MAX_PKT_SIZE_LOG2(4), .MAX_AVG_LOG2(10),
    .DEFAULT_PKT_SIZE(8), .DEFAULT_AVG_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .i_config_tdata(i_config_tdata), .i_config_tvalid(i_config_tvalid),
    .i_config_tready(i_config_tready), .o_len_err(o_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && o_len_err) len_err_cnt++;
    if (!reset && o_tvalid && o_tready) begin
      total++;
      assert (sb.size() != 0) begin
        passed++;
      end else begin
        $error("FAIL unexpected_out: observed %0h expected none", {o_tlast, o_tdata});
      end
      if (sb.size() != 0) begin
        exp_beat = sb.pop_front();
        total++;
        assert ({o_tlast, o_tdata} === exp_beat) begin
          passed++;
        end else begin
          $error("FAIL out_beat: observed %0h expected %0h", {o_tlast, o_tdata}, exp_beat);
        end
      end
    end
  end

  task automatic expect_beat(input logic last, input logic [31:0] d);
    sb.push_back({last, d});
  endtask

  task automatic cfg(input logic mode, input logic [3:0] k, input logic [3:0] nm1);
    i_config_tdata  = {mode, k, nm1};
    i_config_tvalid = 1'b1;
    @(posedge clk); #1;
    i_config_tvalid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int  guard;
    bit  took;
    guard = 0;
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = last;
    do begin
      @(negedge clk);
      took = i_tready;
      @(posedge clk); #1;
      guard++;
    end while (!took && guard < 2000);
    if (!took) chk("send_timeout", 64'(took), 64'd1);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic send4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b1);
  endtask

  task automatic send_n(input logic [31:0] base, input int n);
    for (int b = 0; b < n; b++) send(base + 32'(b), (b == n - 1));
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_tdata = 32'd0;
    i_tlast = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    i_config_tdata = 9'd0;
    i_config_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_o_tlast", 64'(o_tlast), 64'd0);
    chk("rst_len_err", 64'(o_len_err), 64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd1);
    chk("rst_cfg_ready", 64'(i_config_tready), 64'd1);

    // Mean, N=4, K=2
    cfg(1'b0, 4'd2, 4'd3);
    expect_beat(1'b0, 32'd2);
    expect_beat(1'b0, 32'd4);
    expect_beat(1'b0, 32'd4);
    expect_beat(1'b1, 32'd6);
    send4(32'd4, 32'd8, 32'd12, 32'd16);
    send4(32'd0, 32'd0, 32'd0, 32'd0);
    send4(32'd4, 32'd4, 32'd4, 32'd4);
    send4(32'd0, 32'd4, 32'd0, 32'd4);
    wait_drain("drain_mean");

    // Peak, K=1; a K=0 config arrives mid-frame and applies only to the next frame
    cfg(1'b1, 4'd1, 4'd3);
    expect_beat(1'b0, 32'd5);
    expect_beat(1'b0, 32'd9);
    expect_beat(1'b0, 32'd3);
    expect_beat(1'b1, 32'hFFFF_FFFF);
    send4(32'd1, 32'd9, 32'd3, 32'hFFFF_FFFF);
    cfg(1'b1, 4'd0, 4'd3);
    send4(32'd5, 32'd2, 32'd3, 32'd7);
    expect_beat(1'b0, 32'd10);
    expect_beat(1'b0, 32'd20);
    expect_beat(1'b0, 32'd30);
    expect_beat(1'b1, 32'd40);
    send4(32'd10, 32'd20, 32'd30, 32'd40);
    expect_beat(1'b0, 32'd7);
    expect_beat(1'b0, 32'd0);
    expect_beat(1'b0, 32'd0);
    expect_beat(1'b1, 32'hFFFF_FFFE);
    send4(32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE);
    wait_drain("drain_peak");

    // Mean, K=10 with all-ones samples; two invalid words after it are ignored
    cfg(1'b0, 4'd10, 4'd3);
    cfg(1'b0, 4'd11, 4'd3);
    cfg(1'b1, 4'd0, 4'd1);
    for (int b = 0; b < 4; b++) expect_beat(b == 3, 32'hFFFF_FFFF);
    for (int p = 0; p < 1024; p++) send4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_drain("drain_k10");

    // Backpressure: N=16, K=0, FIFO depth 16, output held off
    cfg(1'b0, 4'd0, 4'd15);
    o_tready = 1'b0;
    for (int b = 0; b < 16; b++) expect_beat(b == 15, 32'(b));
    for (int b = 0; b < 16; b++) expect_beat(b == 15, 32'(100 + b));
    send_n(32'd0, 16);
    fork
      send_n(32'd100, 16);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_i_tready", 64'(i_tready), 64'd0);
        chk("stall_o_tvalid", 64'(o_tvalid), 64'd1);
        o_tready = 1'b1;
      end
    join
    wait_drain("drain_stall");

    // Length error: early tlast at idx 2 of packet 1, then a clean frame
    cfg(1'b0, 4'd2, 4'd7);
    send_n(32'd0, 8);
    send(32'd8, 1'b0);
    send(32'd9, 1'b0);
    send(32'd10, 1'b1);
    chk("len_err_pulse", 64'(o_len_err), 64'd1);
    @(posedge clk); #1;
    chk("len_err_clear", 64'(o_len_err), 64'd0);
    for (int b = 0; b < 8; b++) expect_beat(b == 7, 32'(b + 12));
    for (int p = 0; p < 4; p++) send_n(32'(p * 8), 8);
    wait_drain("drain_len_err");

    // Reset mid-ST_ACCUM with results waiting in the FIFO
    o_tready = 1'b0;
    cfg(1'b0, 4'd0, 4'd3);
    send4(32'd1, 32'd2, 32'd3, 32'd4);
    cfg(1'b0, 4'd2, 4'd3);
    send4(32'd9, 32'd9, 32'd9, 32'd9);
    send4(32'd9, 32'd9, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_o_tvalid", 64'(o_tvalid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("post_reset_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("post_reset_i_tready", 64'(i_tready), 64'd1);
    o_tready = 1'b1;
    for (int b = 0; b < 8; b++) expect_beat(b == 7, 32'(b + 12));
    for (int p = 0; p < 4; p++) send_n(32'(p * 8), 8);
    wait_drain("drain_after_reset");

    chk("len_err_count", 64'(len_err_cnt), 64'd1);
    chk("final_o_tvalid", 64'(o_tvalid), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pkt_avg_mode.md
# pkt_avg_mode

Parametrised packet-wise vector averager for the spectrum-sensing datapath. It accumulates 2^K consecutive packets of N unsigned samples bin-by-bin and emits one N-sample result packet per frame. The result is either the truncated mean or the per-bin peak-hold. Unlike the first-generation averager, it applies real input backpressure, checks packet length against `i_tlast`, changes configuration only at frame boundaries, and supports reset-time default configuration.

## Interface
- `WIDTH`, 32, sample width (unsigned magnitude)
- `MAX_PKT_SIZE_LOG2`, 14, RAM/FIFO address width; N ≤ 2^MAX_PKT_SIZE_LOG2
- `MAX_AVG_LOG2`, 10, max K; accumulator width A = WIDTH+MAX_AVG_LOG2
- `DEFAULT_PKT_SIZE`, 1024, N after reset
- `DEFAULT_AVG_LOG2`, 3, K after reset
- `clk` in 1 — sole clock
- `reset` in 1 — synchronous, active-high
- `i_tdata` in WIDTH — input sample
- `i_tlast` in 1 — last sample of input packet
- `i_tvalid` in 1 / `i_tready` out 1 — input handshake
- `o_tdata` out WIDTH / `o_tlast` out 1 / `o_tvalid` out 1 / `o_tready` in 1 — output AXI-stream
- `i_config_tdata` in MAX_PKT_SIZE_LOG2+5 — {mode[1], avg_log2[4], pkt_size_m1[MAX_PKT_SIZE_LOG2]}
- `i_config_tvalid` in 1 / `i_config_tready` out 1 — config handshake; `i_config_tready` is constant 1
- `o_len_err` out 1 — one-cycle pulse on packet-length mismatch

## Operation
- Config word: N = pkt_size_m1+1; K = avg_log2; mode 0 = mean, 1 = peak-hold.
- A config word is ignored if pkt_size_m1 < 3 or avg_log2 > MAX_AVG_LOG2.
- A valid config word is held in a pending register; the last word received wins.
- Active config (N, K, mode) loads from the pending register only at a frame boundary: before the first accepted beat of packet 0.
- States:
  - ST_FIRST: packet 0 of frame. Write the sample (zero-extended to A) to RAM[idx].
  - ST_ACCUM: packets 1..2^K−2. RAM[idx] ← op(RAM[idx], sample).
  - ST_LAST: packet 2^K−1. Compute op(RAM[idx], sample) and push the result to the output FIFO; the RAM write is don't-care.
  - ST_RESYNC: discards input until `i_tlast`.
- Transitions:
  - ST_FIRST→ST_ACCUM, or →ST_LAST if K=1, on the accepted beat at idx=N−1.
  - ST_ACCUM→ST_LAST after packet 2^K−2 completes.
  - ST_LAST→ST_FIRST at end of packet.
  - K=0: ST_FIRST behaves as ST_LAST, giving passthrough with one output packet per input packet.
- op: mean = A-bit unsigned add; peak = unsigned max.
- Output value: mean = acc >> K, truncated to the low WIDTH bits; peak = max, never shifted.
- `o_tlast` on result idx=N−1.
- idx counts accepted beats 0..N−1 and wraps to 0. RAM is read at idx on acceptance and written back one cycle later. N ≥ 4 guarantees no read/write address collision.
- Length check:
  - Trigger: `i_tlast`=1 at idx≠N−1, or `i_tlast`=0 at idx=N−1.
  - Response: pulse `o_len_err`, abandon the frame without output, and reset idx and packet count.
  - If the mismatch beat had `i_tlast`=1, go to ST_FIRST next; otherwise go to ST_RESYNC.
  - ST_RESYNC→ST_FIRST after the accepted beat with `i_tlast`=1. Beats in ST_RESYNC are accepted and dropped.
- A partial result already pushed before the error remains in the FIFO. Its `o_tlast` is forced on the last pushed beat: the FIFO input is the error beat with tlast=1, value 0.
- Output FIFO: depth 2^MAX_PKT_SIZE_LOG2, width WIDTH+1.
- Backpressure: `i_tready`=0 only when the next beat would be idx 0 of ST_LAST (or K=0) and FIFO free space < N. It stays low until space ≥ N. Once ST_LAST starts, `i_tready` stays 1 for the whole packet.

## Timing
- Reset (one cycle suffices), all registers:
  - Control state: ST_FIRST; idx=0; packet count 0.
  - Config: active = pending = defaults, mode 0.
  - Outputs and FIFO: FIFO cleared; `o_tvalid`=0, `o_tlast`=0, `o_len_err`=0.
  - `i_tready`=1 the cycle after reset deasserts.
- Reset mid-frame discards all accumulation and FIFO contents.
- Accepted beat at cycle t → result written to the FIFO at t+2 → `o_tvalid` no earlier than t+3.
- Throughput: 1 beat/cycle in all states while `i_tready`=1. `i_tvalid` gaps are allowed anywhere.
- `o_len_err` is asserted the cycle after the offending beat is accepted.
- Config received at the same cycle as the last beat of a frame applies to the next frame.

## Test plan
- N=4, K=2, mean; four packets with bin values {4,8,12,16}, {0,0,0,0}, {4,4,4,4}, {0,4,0,4} → one packet {2,4,4,6}, `o_tlast` on the 4th beat, no other output.
- Peak mode, N=4, K=1; packets {1,9,3,0xFFFFFFFF}, {5,2,3,7} → {5,9,3,0xFFFFFFFF}. Then K=0 config sent mid-frame → takes effect only after the current frame; afterwards each input packet is echoed unchanged.
- Mean, K=10, all samples 0xFFFFFFFF → output 0xFFFFFFFF (no accumulator overflow).
- `o_tready`=0 held, N=16, K=0 → second packet's first beat stalled (`i_tready`=0) until the FIFO drains to 16 free entries; no data lost or reordered.
- `i_tlast` early at idx 2 of packet 1 (N=8, K=2) → `o_len_err` pulse, no output. The next 2^K clean packets produce a correct result.
- Reset asserted mid-ST_ACCUM with FIFO non-empty → `o_tvalid`=0 the next cycle; a following clean frame uses default N/K and averages correctly.
